// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit/receive blocks.
//   uart_tx_state_t          : transmit FSM state encoding
//   UART_DATA_BITS           : data bits per frame
//   UART_DEFAULT_CLKS_PER_BIT: 100 MHz clock / 115200 baud
//   even_parity()            : even parity over one data byte
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } uart_tx_state_t;

  // The even-parity bit makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] i_data);
    return ^i_data;
  endfunction

endpackage

// File: rtl/uart_tx_drain_if.sv
// ---------------------------------------------------------------------------
// uart_tx_drain_if
// Read-side handshake between the transmit FIFO and the UART drain.
//   fifo_empty : FIFO empty flag (FIFO -> drain)
//   fifo_data  : registered FIFO data_out, valid the cycle after fifo_read
//   fifo_read  : one-cycle pop strobe (drain -> FIFO)
// Modports: master = the drain (issues pops), slave = the FIFO.
// ---------------------------------------------------------------------------
interface uart_tx_drain_if;
  import uart_pkg::*;

  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_data;
  logic                      fifo_read;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_read
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_read
  );

endinterface

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer. Counts 0..CLKS_PER_BIT-1, flags the terminal count and
// wraps to 0. Shared by the TX and RX sides.
//   clk     : system clock
//   reset   : synchronous, active-high
//   i_clear : restart the count at 0 on the next edge
//   o_tick  : high during the last cycle of each bit period
// ---------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int              CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Bit-period counter: clear has priority, then wrap on terminal count.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt == TERM) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_tick = (r_cnt == TERM);

endmodule

// File: rtl/uart_tx_drain.sv
// ---------------------------------------------------------------------------
// uart_tx_drain
// Pops bytes from the transmit FIFO one at a time and serialises each one
// as an 8N1 / 8N2 frame, or 8E1 / 8E2 when UART_TX_PARITY_EN is defined.
//   clk          : system clock
//   reset        : synchronous, active-high
//   i_tx_enable  : low blocks new pops; a frame in progress still completes
//   fifo_if      : FIFO read handshake (master side: fifo_read out,
//                  fifo_empty / fifo_data in)
//   o_tx         : serial line, idle high
//   o_busy       : high in every state except IDLE
//   o_frame_done : pulse on the last cycle of the final stop bit
// Build option: `define UART_TX_PARITY_EN inserts one even-parity bit
// between the data and stop bits.
// All outputs decode from state/counter registers only.
// ---------------------------------------------------------------------------
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_tx_enable,
  uart_tx_drain_if.master        fifo_if,
  output logic                   o_tx,
  output logic                   o_busy,
  output logic                   o_frame_done
);

  uart_tx_state_t            r_state;
  uart_tx_state_t            w_state_next;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [2:0]                r_bit_cnt;
  logic                      r_stop_cnt;
`ifdef UART_TX_PARITY_EN
  logic                      r_parity;
`endif

  logic w_tick;
  logic w_baud_clear;
  logic w_last_data;
  logic w_last_stop;
  logic w_tx;
  logic w_fifo_read;

  // The counter restarts while LOAD is active so START gets a full period.
  assign w_baud_clear = (r_state == LOAD);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_baud_clear),
    .o_tick  (w_tick)
  );

  assign w_last_data = w_tick && (r_bit_cnt == 3'd7);
  // With one stop bit the stop counter is irrelevant.
  assign w_last_stop = w_tick && ((STOP_BITS == 1) || (r_stop_cnt == 1'b1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_state_next = r_state;
    w_tx         = 1'b1;
    w_fifo_read  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_tx_enable && !fifo_if.fifo_empty) begin
          w_state_next = POP;
        end else begin
          w_state_next = IDLE;
        end
      end
      POP: begin
        w_fifo_read  = 1'b1;
        w_state_next = LOAD;
      end
      LOAD: begin
        w_state_next = START;
      end
      START: begin
        w_tx = 1'b0;
        if (w_tick) begin
          w_state_next = DATA;
        end else begin
          w_state_next = START;
        end
      end
      DATA: begin
        w_tx = r_shift[0];
        if (w_last_data) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = PARITY;
`else
          w_state_next = STOP;
`endif
        end else begin
          w_state_next = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        w_tx = r_parity;
        if (w_tick) begin
          w_state_next = STOP;
        end else begin
          w_state_next = PARITY;
        end
      end
`endif
      STOP: begin
        if (w_last_stop) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = STOP;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Shift register, bit/stop counters and parity: loaded in LOAD,
  // advanced on each bit-period tick of their own state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift    <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else if (r_state == LOAD) begin
      r_shift    <= fifo_if.fifo_data;
      r_bit_cnt  <= 3'd0;
      r_stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= even_parity(fifo_if.fifo_data);
`endif
    end else if ((r_state == DATA) && w_tick) begin
      r_shift   <= {1'b0, r_shift[UART_DATA_BITS-1:1]};
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end else if ((r_state == STOP) && w_tick) begin
      r_stop_cnt <= r_stop_cnt + 1'b1;
    end
  end

  assign fifo_if.fifo_read = w_fifo_read;
  assign o_tx              = w_tx;
  assign o_busy            = (r_state != IDLE);
  assign o_frame_done      = (r_state == STOP) && w_last_stop;

endmodule

// File: tb/tb_uart_tx_drain.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_drain
// Directed bench: two drains (one and two stop bits, CLKS_PER_BIT=4), each
// fed by a small registered-output FIFO model.
// ---------------------------------------------------------------------------
module tb_uart_tx_drain;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en1 = 1'b1;
  logic en2 = 1'b1;
  logic tx1, busy1, fd1, tx2, busy2, fd2;

  int total = 0;
  int bad   = 0;
  int sel   = 1;

  always #5 clk = ~clk;

  uart_tx_drain_if fifo_if1 ();
  uart_tx_drain_if fifo_if2 ();

  uart_tx_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut1 (
    .clk (clk), .reset (reset), .i_tx_enable (en1), .fifo_if (fifo_if1),
    .o_tx (tx1), .o_busy (busy1), .o_frame_done (fd1)
  );

  uart_tx_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut2 (
    .clk (clk), .reset (reset), .i_tx_enable (en2), .fifo_if (fifo_if2),
    .o_tx (tx2), .o_busy (busy2), .o_frame_done (fd2)
  );

  // FIFO models: registered data_out, pointer advances on read.
  logic [7:0] mem1 [0:15];
  logic [7:0] mem2 [0:15];
  int wr1 = 0, rd1 = 0, wr2 = 0, rd2 = 0;
  logic [7:0] dout1 = 8'h00, dout2 = 8'h00;
  int reads1 = 0, reads2 = 0;

  // FIFO 1 read port.
  always @(posedge clk) begin
    if (fifo_if1.fifo_read) begin
      dout1 <= mem1[rd1[3:0]];
      rd1   <= rd1 + 1;
    end
  end

  // FIFO 2 read port.
  always @(posedge clk) begin
    if (fifo_if2.fifo_read) begin
      dout2 <= mem2[rd2[3:0]];
      rd2   <= rd2 + 1;
    end
  end

  // Pop-strobe counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (fifo_if1.fifo_read) reads1 <= reads1 + 1;
    if (fifo_if2.fifo_read) reads2 <= reads2 + 1;
  end

  assign fifo_if1.fifo_empty = (rd1 == wr1);
  assign fifo_if1.fifo_data  = dout1;
  assign fifo_if2.fifo_empty = (rd2 == wr2);
  assign fifo_if2.fifo_data  = dout2;

  wire w_tx   = (sel == 2) ? tx2   : tx1;
  wire w_busy = (sel == 2) ? busy2 : busy1;
  wire w_fd   = (sel == 2) ? fd2   : fd1;
  wire w_rd   = (sel == 2) ? fifo_if2.fifo_read : fifo_if1.fifo_read;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic push(input int which, input logic [7:0] b);
    if (which == 2) begin
      mem2[wr2[3:0]] = b;
      wr2++;
    end else begin
      mem1[wr1[3:0]] = b;
      wr1++;
    end
  endtask

  // Expected line levels per bit: start, data LSB first, [parity], stops.
  function automatic logic [15:0] frame_bits(input logic [7:0] b, input int stops);
    logic [15:0] f;
    f = 16'h0000;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    for (int s = 0; s < stops; s++) f[9 + PB + s] = 1'b1;
    return f;
  endfunction

  // Wait (bounded) for the first cycle of a start bit; count high cycles seen.
  task automatic wait_start(output int highs);
    bit found;
    found = 1'b0;
    highs = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (w_tx === 1'b0) begin
        found = 1'b1;
        break;
      end
      highs++;
    end
    if (!found) check_val("start_timeout", 32'd0, 32'd1);
  endtask

  // Check every cycle of a frame; entered on the first start-bit cycle.
  task automatic check_frame(input logic [7:0] b, input int stops, input int drop_idx);
    logic [15:0] f;
    int ncyc;
    f = frame_bits(b, stops);
    ncyc = (9 + PB + stops) * CPB;
    for (int idx = 0; idx < ncyc; idx++) begin
      if (idx > 0) @(negedge clk);
      check_val($sformatf("tx_%0h_bit%0d", b, idx / CPB), {31'd0, w_tx}, {31'd0, f[idx / CPB]});
      check_val($sformatf("busy_%0h_c%0d", b, idx), {31'd0, w_busy}, 32'd1);
      check_val($sformatf("fdone_%0h_c%0d", b, idx), {31'd0, w_fd}, (idx == ncyc - 1) ? 32'd1 : 32'd0);
      if (idx == drop_idx) begin
        if (sel == 2) en2 = 1'b0;
        else          en1 = 1'b0;
      end
    end
  endtask

  initial begin
    int highs;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int highs;
    // Reset with a byte waiting and enable high.
    sel = 1;
    push(1, 8'hA5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_tx", {31'd0, tx1}, 32'd1);
    check_val("rst_read", {31'd0, fifo_if1.fifo_read}, 32'd0);
    check_val("rst_busy", {31'd0, busy1}, 32'd0);
    reset = 1'b0;
    #1;
    check_val("post_rst_tx", {31'd0, tx1}, 32'd1);
    check_val("post_rst_read", {31'd0, fifo_if1.fifo_read}, 32'd0);
    check_val("post_rst_busy", {31'd0, busy1}, 32'd0);

    // Single 0xA5 frame: POP and LOAD precede the start bit.
    wait_start(highs);
    check_val("pop_latency", highs, 32'd2);
    check_frame(8'hA5, 1, -1);
    check_val("reads_a5", reads1, 32'd1);

    // Back-to-back 0xA5, 0x07 with a 3-cycle gap.
    push(1, 8'hA5);
    push(1, 8'h07);
    wait_start(highs);
    check_val("gap0", highs, 32'd3);
    check_frame(8'hA5, 1, -1);
    wait_start(highs);
    check_val("gap1", highs, 32'd3);
    check_frame(8'h07, 1, -1);
    check_val("reads_b2b", reads1, 32'd3);

    // Two stop bits, byte 0x00.
    sel = 2;
    push(2, 8'h00);
    wait_start(highs);
    check_frame(8'h00, 2, -1);
    check_val("reads2", reads2, 32'd1);

    // Enable dropped during a DATA bit of 0x3C.
    sel = 1;
    push(1, 8'h3C);
    push(1, 8'h55);
    wait_start(highs);
    check_frame(8'h3C, 1, 2 * CPB);
    repeat (10) @(negedge clk);
    check_val("stall_reads", reads1, 32'd4);
    check_val("stall_tx", {31'd0, tx1}, 32'd1);
    check_val("stall_busy", {31'd0, busy1}, 32'd0);
    en1 = 1'b1;
    @(negedge clk);
    check_val("resume_read", {31'd0, w_rd}, 32'd1);
    wait_start(highs);
    check_val("resume_latency", highs, 32'd1);
    check_frame(8'h55, 1, -1);
    check_val("reads_resume", reads1, 32'd5);

    // Reset during data bit 4 of 0xFF; next frame carries 0x12.
    push(1, 8'hFF);
    push(1, 8'h12);
    wait_start(highs);
    repeat (5 * CPB) @(negedge clk);
    check_val("ff_bit4", {31'd0, tx1}, 32'd1);
    check_val("ff_busy", {31'd0, busy1}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_val("midrst_tx", {31'd0, tx1}, 32'd1);
    check_val("midrst_busy", {31'd0, busy1}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_start(highs);
    check_frame(8'h12, 1, -1);
    check_val("reads_final", reads1, 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
